fir_axis_out: RTL

Output stream stage placed directly downstream of the FIR PE. It accepts one result word per `res_valid`/`res_ready` handshake into a small register FIFO and presents results as an AXI-Stream master (`sm_*`). It counts delivered beats against the programmed data length, asserts `sm_tlast` on the final beat and pulses `done` when that beat is accepted, so the control block can set `ap_done`/`ap_idle`. The FIFO absorbs downstream backpressure and throttles the PE through `res_ready`.

---
 rtl/fir_axis_out.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_axis_out.sv
// FIR result output stage: buffers PE results and streams them as AXI-Stream with tlast/done framing.
// 1-cycle push-to-tvalid latency; res_ready drops when the FIFO is full or the frame's inputs are all taken.

module fir_axis_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          axis_clk,
    input  logic          axis_rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is reset so the read port presents zero straight out of reset.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module fir_axis_out #(
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int pLEN_WIDTH  = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pLEN_WIDTH-1:0]  data_length,
    input  logic                   res_valid,
    input  logic [pDATA_WIDTH-1:0] res_data,
    output logic                   res_ready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic                   done,
    output logic                   busy,
    output logic [pLEN_WIDTH-1:0]  out_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [pLEN_WIDTH-1:0] len_q, in_cnt_q, out_cnt_q;
    logic                  start_eff, push, pop, fifo_full, fifo_empty;

    assign start_eff = start && (state_q == S_IDLE);
    assign push      = res_valid && res_ready;
    assign pop       = sm_tvalid && sm_tready;

    fir_axis_out_fifo #(
        .DW    (pDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clr        (start_eff),
        .push       (push),
        .push_dat   (res_data),
        .pop        (pop),
        .pop_dat    (sm_tdata),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (data_length == '0) ? S_DONE : S_RUN;
            S_RUN:  if (pop && sm_tlast) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (start_eff) begin
            len_q     <= data_length;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (push) in_cnt_q  <= in_cnt_q + 1'b1;
            if (pop)  out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    // Full blocks input even when a pop is pending: no same-cycle pass-through.
    assign res_ready = (state_q == S_RUN) && !fifo_full && (in_cnt_q < len_q);
    assign sm_tvalid = !fifo_empty;
    assign sm_tlast  = sm_tvalid && (out_cnt_q == len_q - 1'b1);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_cnt   = out_cnt_q;
endmodule
